// File: rtl/ps2_ace_keymatrix.sv
// ps2_ace_keymatrix: PS/2 set-2 key events to Jupiter Ace 8x5 keyboard matrix,
// with PC-key expansion and a Ctrl+Alt+Del / F12 reset request pulse.
module ps2_ace_keymatrix #(
    parameter int RESET_PULSE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  row_sel,
    output logic [4:0]  columns,
    output logic        kbd_reset
);
    localparam int         NF   = 49;
    localparam logic [5:0] NONE = 6'd63;

    // Flag layout: 0..39 matrix position row*5+col (0 = LShift, 1 = LCtrl),
    // 40 RShift, 41 RCtrl, 42 LAlt, 43 RAlt, 44..48 Backspace/Left/Right/Up/Down.
    function automatic logic [5:0] key_index(input logic [8:0] k);
        case (k)
            9'h012: key_index = 6'd0;
            9'h014: key_index = 6'd1;
            9'h01A: key_index = 6'd2;
            9'h022: key_index = 6'd3;
            9'h021: key_index = 6'd4;
            9'h01C: key_index = 6'd5;
            9'h01B: key_index = 6'd6;
            9'h023: key_index = 6'd7;
            9'h02B: key_index = 6'd8;
            9'h034: key_index = 6'd9;
            9'h015: key_index = 6'd10;
            9'h01D: key_index = 6'd11;
            9'h024: key_index = 6'd12;
            9'h02D: key_index = 6'd13;
            9'h02C: key_index = 6'd14;
            9'h016: key_index = 6'd15;
            9'h01E: key_index = 6'd16;
            9'h026: key_index = 6'd17;
            9'h025: key_index = 6'd18;
            9'h02E: key_index = 6'd19;
            9'h045: key_index = 6'd20;
            9'h046: key_index = 6'd21;
            9'h03E: key_index = 6'd22;
            9'h03D: key_index = 6'd23;
            9'h036: key_index = 6'd24;
            9'h04D: key_index = 6'd25;
            9'h044: key_index = 6'd26;
            9'h043: key_index = 6'd27;
            9'h03C: key_index = 6'd28;
            9'h035: key_index = 6'd29;
            9'h05A: key_index = 6'd30;
            9'h04B: key_index = 6'd31;
            9'h042: key_index = 6'd32;
            9'h03B: key_index = 6'd33;
            9'h033: key_index = 6'd34;
            9'h029: key_index = 6'd35;
            9'h03A: key_index = 6'd36;
            9'h031: key_index = 6'd37;
            9'h032: key_index = 6'd38;
            9'h02A: key_index = 6'd39;
            9'h059: key_index = 6'd40;
            9'h114: key_index = 6'd41;
            9'h011: key_index = 6'd42;
            9'h111: key_index = 6'd43;
            9'h066: key_index = 6'd44;
            9'h16B: key_index = 6'd45;
            9'h174: key_index = 6'd46;
            9'h175: key_index = 6'd47;
            9'h172: key_index = 6'd48;
            default: key_index = NONE;
        endcase
    endfunction

    logic [10:0]   key_q;
    logic          prev_q;
    logic          arm_q;
    logic [NF-1:0] flags_q, flags_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          evt, del_hit, f12_hit, trig;
    logic [5:0]    idx;
    logic [39:0]   eff;

    always_comb begin
        evt     = arm_q && (key_q[10] != prev_q);
        idx     = key_index(key_q[8:0]);
        flags_d = flags_q;
        if (evt && idx != NONE)
            flags_d[idx] = key_q[9];
        // Modifier state is taken before this event is applied.
        del_hit = key_q[8:0] == 9'h171 && (flags_q[1] | flags_q[41]) && (flags_q[42] | flags_q[43]);
        f12_hit = key_q[8:0] == 9'h007;
        trig    = evt && key_q[9] && (del_hit || f12_hit);
        cnt_d   = trig ? 8'(RESET_PULSE) : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
    end

    always_comb begin
        eff     = flags_q[39:0];
        eff[0]  = eff[0] | flags_q[40] | (|flags_q[48:44]);
        eff[1]  = eff[1] | flags_q[41];
        eff[20] = eff[20] | flags_q[44];
        eff[19] = eff[19] | flags_q[45];
        eff[22] = eff[22] | flags_q[46];
        eff[23] = eff[23] | flags_q[47];
        eff[24] = eff[24] | flags_q[48];
        columns = 5'h1F;
        for (int r = 0; r < 8; r++)
            if (!row_sel[r])
                columns = columns & ~eff[r*5 +: 5];
    end

    assign kbd_reset = cnt_q == 8'd0;

    // The first cycle out of reset only aligns prev_q with the toggle bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            key_q   <= ps2_key;
            prev_q  <= arm_q ? key_q[10] : ps2_key[10];
            arm_q   <= 1'b1;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ps2_ace_keymatrix.sv
// tb_ps2_ace_keymatrix: directed scenarios plus randomized event bursts checked
// against a held-key model of the Ace keyboard matrix.
module tb_ps2_ace_keymatrix;
    logic        clk = 0;
    logic        reset = 0;
    logic [10:0] ps2_key = '0;
    logic [7:0]  row_sel = 8'hFF;
    logic [4:0]  columns;
    logic        kbd_reset;

    int tests = 0;
    int fails = 0;
    bit tog = 0;
    bit held [0:511];

    // Primary key code per matrix position row*5+col.
    logic [8:0] rc [0:39] = '{
        9'h012, 9'h014, 9'h01A, 9'h022, 9'h021,
        9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
        9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
        9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
        9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
        9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
        9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
        9'h029, 9'h03A, 9'h031, 9'h032, 9'h02A};
    logic [8:0] cc [0:4] = '{9'h066, 9'h16B, 9'h174, 9'h175, 9'h172};
    int         cp [0:4] = '{20, 19, 22, 23, 24};
    logic [8:0] ex [0:3] = '{9'h059, 9'h114, 9'h011, 9'h111};

    ps2_ace_keymatrix #(.RESET_PULSE(16)) dut (
        .clk(clk), .reset(reset), .ps2_key(ps2_key),
        .row_sel(row_sel), .columns(columns), .kbd_reset(kbd_reset));

    always #5 clk = ~clk;

    function automatic bit active(input int r, input int c);
        int  p = r * 5 + c;
        bit  a = held[rc[p]];
        if (p == 0) a = a | held[9'h059];
        if (p == 1) a = a | held[9'h114];
        for (int j = 0; j < 5; j++)
            if (held[cc[j]] && (p == 0 || p == cp[j])) a = 1;
        return a;
    endfunction

    function automatic logic [4:0] model_cols(input logic [7:0] sel);
        logic [4:0] e = 5'h1F;
        for (int r = 0; r < 8; r++)
            if (!sel[r])
                for (int c = 0; c < 5; c++)
                    if (active(r, c)) e[c] = 1'b0;
        return e;
    endfunction

    function automatic bit in_pool(input logic [8:0] k);
        for (int i = 0; i < 40; i++) if (rc[i] == k) return 1;
        for (int i = 0; i < 5; i++) if (cc[i] == k) return 1;
        for (int i = 0; i < 4; i++) if (ex[i] == k) return 1;
        return 0;
    endfunction

    task automatic drive(input bit press, input bit ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, press, ext, code};
        held[{ext, code}] = press;
    endtask

    task automatic send(input bit press, input bit ext, input logic [7:0] code);
        @(negedge clk);
        drive(press, ext, code);
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 512; i++) held[i] = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_model();
        row_sel = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL reset_columns got %h want 1f", columns); end
        tests++;
        if (kbd_reset !== 1'b1) begin fails++; $display("FAIL reset_kbd_reset got %b want 1", kbd_reset); end
        reset = 1;
        repeat (2) @(negedge clk);
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL post_reset_columns got %h want 1f", columns); end
    endtask

    task automatic test_basic();
        row_sel = 8'hFE;
        send(1, 0, 8'h1A);
        @(negedge clk);
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL basic_latency1 got %h want 1f", columns); end
        @(negedge clk);
        tests++;
        if (columns !== 5'h1B) begin fails++; $display("FAIL basic_press got %h want 1b", columns); end
        send(0, 0, 8'h1A);
        settle();
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL basic_release got %h want 1f", columns); end
    endtask

    task automatic test_compound();
        send(1, 0, 8'h66);
        settle();
        row_sel = 8'hFE; #1;
        tests++;
        if (columns !== 5'h1E) begin fails++; $display("FAIL bksp_shift got %h want 1e", columns); end
        row_sel = 8'hEF; #1;
        tests++;
        if (columns !== 5'h1E) begin fails++; $display("FAIL bksp_zero got %h want 1e", columns); end
        send(1, 0, 8'h45);
        send(0, 0, 8'h66);
        settle();
        row_sel = 8'hEF; #1;
        tests++;
        if (columns !== 5'h1E) begin fails++; $display("FAIL zero_kept got %h want 1e", columns); end
        row_sel = 8'hFE; #1;
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL shift_dropped got %h want 1f", columns); end
        send(1, 1, 8'h75);
        settle();
        row_sel = 8'hEE; #1;
        tests++;
        if (columns !== 5'h16) begin fails++; $display("FAIL up_arrow got %h want 16", columns); end
        send(0, 1, 8'h75);
        send(0, 0, 8'h45);
        settle();
        row_sel = 8'hEE; #1;
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL compound_release got %h want 1f", columns); end
    endtask

    task automatic test_reset_pulse();
        send(1, 0, 8'h14);
        send(1, 0, 8'h11);
        send(1, 1, 8'h71);
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            tests++;
            if (kbd_reset !== !(i >= 2 && i <= 25)) begin
                fails++;
                $display("FAIL pulse_cycle_%0d got %b want %b", i, kbd_reset, !(i >= 2 && i <= 25));
            end
            if (i == 8) drive(1, 0, 8'h07);
        end
        send(0, 1, 8'h71);
        send(0, 0, 8'h07);
        send(0, 0, 8'h14);
        send(0, 0, 8'h11);
        send(1, 1, 8'h71);
        repeat (4) @(negedge clk);
        tests++;
        if (kbd_reset !== 1'b1) begin fails++; $display("FAIL del_without_mods got %b want 1", kbd_reset); end
        send(0, 1, 8'h71);
        settle();
    endtask

    task automatic test_async_midpulse();
        send(1, 0, 8'h07);
        repeat (5) @(negedge clk);
        tests++;
        if (kbd_reset !== 1'b0) begin fails++; $display("FAIL f12_pulse got %b want 0", kbd_reset); end
        reset = 0;
        clear_model();
        #1;
        tests++;
        if (kbd_reset !== 1'b1) begin fails++; $display("FAIL async_clear got %b want 1", kbd_reset); end
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_toggle_through_reset();
        reset = 0;
        clear_model();
        tog = 1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h1A};
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        row_sel = 8'h00; #1;
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL no_spurious got %h want 1f", columns); end
        send(1, 0, 8'h29);
        settle();
        row_sel = 8'h7F; #1;
        tests++;
        if (columns !== 5'h1E) begin fails++; $display("FAIL space_row7 got %h want 1e", columns); end
        send(0, 0, 8'h29);
        settle();
    endtask

    task automatic test_multirow();
        send(1, 0, 8'h1A);
        send(1, 0, 8'h1C);
        settle();
        row_sel = 8'hFC; #1;
        tests++;
        if (columns !== 5'h1A) begin fails++; $display("FAIL multirow got %h want 1a", columns); end
        row_sel = 8'hFF; #1;
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL no_row got %h want 1f", columns); end
        send(0, 0, 8'h1A);
        send(0, 0, 8'h1C);
        settle();
    endtask

    task automatic test_unmapped();
        row_sel = 8'h00;
        send(1, 0, 8'h0E);
        send(1, 1, 8'h1A);
        send(0, 0, 8'h22);
        settle();
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL unmapped got %h want 1f", columns); end
        send(0, 1, 8'h1A);
        send(1, 1, 8'h29);
        settle();
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL wrong_ext got %h want 1f", columns); end
        send(0, 1, 8'h29);
    endtask

    task automatic test_back_to_back();
        send(1, 0, 8'h1A);
        send(0, 0, 8'h1A);
        send(1, 0, 8'h1C);
        send(1, 0, 8'h1B);
        settle();
        row_sel = 8'hFE; #1;
        tests++;
        if (columns !== 5'h1F) begin fails++; $display("FAIL press_release got %h want 1f", columns); end
        row_sel = 8'hFD; #1;
        tests++;
        if (columns !== 5'h1C) begin fails++; $display("FAIL b2b_presses got %h want 1c", columns); end
        send(0, 0, 8'h1C);
        send(0, 0, 8'h1B);
        settle();
    endtask

    task automatic test_random();
        logic [8:0] k;
        logic [7:0] sel;
        for (int b = 0; b < 40; b++) begin
            for (int e = 0, n = $urandom_range(1, 6); e < n; e++) begin
                int p = $urandom_range(0, 48);
                if ($urandom_range(0, 4) == 0) begin
                    do k = 9'($urandom_range(0, 511));
                    while (in_pool(k) || k == 9'h007 || k == 9'h171);
                end else
                    k = p < 40 ? rc[p] : (p < 45 ? cc[p-40] : ex[p-45]);
                send($urandom_range(0, 9) < 6, k[8], k[7:0]);
            end
            settle();
            for (int r = 0; r < 9; r++) begin
                sel = r < 8 ? ~(8'd1 << r) : 8'($urandom);
                row_sel = sel; #1;
                tests++;
                if (columns !== model_cols(sel)) begin
                    fails++;
                    $display("FAIL random_b%0d_sel%h got %h want %h", b, sel, columns, model_cols(sel));
                end
            end
            tests++;
            if (kbd_reset !== 1'b1) begin fails++; $display("FAIL random_kbd_reset got %b want 1", kbd_reset); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compound();
        test_reset_pulse();
        test_async_midpulse();
        test_toggle_through_reset();
        test_multirow();
        test_unmapped();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
